// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// The opcode values must match the ALU's own opcode encoding.
package alu_arbiter_pkg;

    // Opcodes the arbiter and its users refer to.
    // ALU_NOP is deliberately outside the ALU's decode space, so the ALU returns 0 for it.
    localparam logic [4:0] ALU_ADD = 5'h00;
    localparam logic [4:0] ALU_SUB = 5'h01;
    localparam logic [4:0] ALU_AND = 5'h02;
    localparam logic [4:0] ALU_OR  = 5'h03;
    localparam logic [4:0] ALU_XOR = 5'h04;
    localparam logic [4:0] ALU_DIV = 5'h05;
    localparam logic [4:0] ALU_NOP = 5'h1F;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PEND = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle between the two requesters, the arbiter and the ALU.
// The slave modport is the arbiter's view; the master modport is the requesters' and ALU's view.
interface alu_arbiter_if #(
    parameter int W   = 32,
    parameter int OPW = 5
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [OPW-1:0] req0_op, req1_op;
    logic [W-1:0]   req0_a, req1_a;
    logic [W-1:0]   req0_b, req1_b;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_r1, alu_r2;
    logic [W-1:0]   alu_res;
    logic           alu_zero;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_res;
    logic           rsp_zero;

    modport slave (
        input  req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
        input  alu_res, alu_zero, rsp_ready,
        output req_ready, alu_op, alu_r1, alu_r2,
        output rsp_valid, rsp_id, rsp_res, rsp_zero
    );

    modport master (
        output req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
        output alu_res, alu_zero, rsp_ready,
        input  req_ready, alu_op, alu_r1, alu_r2,
        input  rsp_valid, rsp_id, rsp_res, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, and a pointer that moves
// to the loser after every grant so a persistent pair alternates.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic rr;
    logic win;

    always_comb begin
        win = (req == 2'b11) ? rr : req[1];
        gnt = 2'b00;
        if (en && req != 2'b00)
            gnt = win ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr <= 1'b0;
        else if (|gnt)
            rr <= ~win;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters with a single response channel.
// Optional: define ALU_ARB_DIVZERO_EN to intercept divide-by-zero and return all-ones.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W   = 32,
    parameter int OPW = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_arbiter_if.slave bus
);
    arb_state_e     state, state_nxt;
    logic [1:0]     gnt;
    logic           can_issue, grant, win;
    logic [OPW-1:0] win_op;
    logic [W-1:0]   win_a, win_b;
    logic           id_q, hold_id, hold_zero;
    logic [W-1:0]   hold_res;
    logic [W-1:0]   pend_res;
    logic           pend_zero;
    logic           dz_hit;

    // Gating with rst_n keeps req_ready low while reset is asserted.
    assign can_issue = (state == ARB_IDLE) | bus.rsp_ready;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.req_valid),
        .en    (can_issue & rst_n),
        .gnt   (gnt)
    );

    assign grant         = |gnt;
    assign win           = gnt[1];
    assign win_op        = win ? bus.req1_op : bus.req0_op;
    assign win_a         = win ? bus.req1_a  : bus.req0_a;
    assign win_b         = win ? bus.req1_b  : bus.req0_b;
    assign bus.req_ready = gnt;

`ifdef ALU_ARB_DIVZERO_EN
    logic dz_q;
    assign dz_hit = grant && (win_op == OPW'(ALU_DIV)) && (win_b == '0);

    // PEND always directly follows a grant, so last cycle's dz_hit describes the pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dz_q <= 1'b0;
        else        dz_q <= dz_hit;
    end

    assign pend_res  = dz_q ? '1   : bus.alu_res;
    assign pend_zero = dz_q ? 1'b0 : bus.alu_zero;
`else
    assign dz_hit    = 1'b0;
    assign pend_res  = bus.alu_res;
    assign pend_zero = bus.alu_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: state_nxt = grant ? ARB_PEND : ARB_IDLE;
            ARB_PEND,
            ARB_HOLD: begin
                if (bus.rsp_ready)          state_nxt = grant ? ARB_PEND : ARB_IDLE;
                else                        state_nxt = ARB_HOLD;
            end
            default:                        state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q      <= 1'b0;
            hold_id   <= 1'b0;
            hold_res  <= '0;
            hold_zero <= 1'b0;
        end else begin
            if (grant)
                id_q <= win;
            if (state == ARB_PEND && !bus.rsp_ready) begin
                hold_res  <= pend_res;
                hold_zero <= pend_zero;
                hold_id   <= id_q;
            end
        end
    end

    always_comb begin
        bus.alu_op    = OPW'(ALU_NOP);
        bus.alu_r1    = '0;
        bus.alu_r2    = '0;
        bus.rsp_valid = (state != ARB_IDLE);
        bus.rsp_id    = 1'b0;
        bus.rsp_res   = '0;
        bus.rsp_zero  = 1'b0;
        if (grant) begin
            bus.alu_op = dz_hit ? OPW'(ALU_NOP) : win_op;
            bus.alu_r1 = win_a;
            bus.alu_r2 = win_b;
        end
        case (state)
            ARB_PEND: begin
                bus.rsp_id   = id_q;
                bus.rsp_res  = pend_res;
                bus.rsp_zero = pend_zero;
            end
            ARB_HOLD: begin
                bus.rsp_id   = hold_id;
                bus.rsp_res  = hold_res;
                bus.rsp_zero = hold_zero;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: registered ALU model, response scoreboard, directed checks.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    alu_arbiter_if #(.W(32), .OPW(5)) bus ();

    alu_arbiter #(.W(32), .OPW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_DIV: return (b == 0) ? 32'd0 : a / b;
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the registered ALU
    always @(posedge clk) begin
        bus.alu_res  <= alu_f(bus.alu_op, bus.alu_r1, bus.alu_r2);
        bus.alu_zero <= (alu_f(bus.alu_op, bus.alu_r1, bus.alu_r2) == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop on response accept, push on request handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_res", bus.rsp_res, e.res);
                    chk("rsp_zero", bus.rsp_zero, e.zero);
                end
            end
            if ((bus.req_valid & bus.req_ready) != 2'b00) begin
                exp_t e;
                logic [4:0]  op;
                logic [31:0] a, b;
                e.id = bus.req_ready[1];
                op   = e.id ? bus.req1_op : bus.req0_op;
                a    = e.id ? bus.req1_a  : bus.req0_a;
                b    = e.id ? bus.req1_b  : bus.req0_b;
                e.res  = alu_f(op, a, b);
                e.zero = (e.res == 32'd0);
`ifdef ALU_ARB_DIVZERO_EN
                if (op == ALU_DIV && b == 32'd0) begin
                    e.res  = 32'hFFFF_FFFF;
                    e.zero = 1'b0;
                end
`endif
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] v,
                       input logic [4:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [4:0] o1, input logic [31:0] a1, input logic [31:0] b1);
        bus.req_valid = v;
        bus.req0_op = o0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_op = o1; bus.req1_a = a1; bus.req1_b = b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        drv(2'b01, ALU_ADD, 1, 1, ALU_ADD, 0, 0);
        bus.rsp_ready = 1'b1;
        #3;
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_alu_op", bus.alu_op, ALU_NOP);
        drv(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
        #9 rst_n = 1'b1;
        step();

        // Both requesters valid every cycle: alternate with no bubble
        drv(2'b11, ALU_SUB, 3, 3, ALU_OR, 1, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt", bus.req_ready, (i % 2) ? 2'b10 : 2'b01);
            if (i > 0) chk("no_bubble", bus.rsp_valid, 1);
            step();
        end
        drv(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
        step();

        // Single requester, one-cycle latency
        drv(2'b01, ALU_ADD, 5, 7, ALU_ADD, 0, 0);
        @(negedge clk);
        chk("add_ready", bus.req_ready, 2'b01);
        chk("add_alu_op", bus.alu_op, ALU_ADD);
        chk("add_alu_r1", bus.alu_r1, 5);
        chk("add_alu_r2", bus.alu_r2, 7);
        step();
        drv(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
        @(negedge clk);
        chk("add_rsp_valid", bus.rsp_valid, 1);
        chk("add_rsp_id", bus.rsp_id, 0);
        chk("add_rsp_res", bus.rsp_res, 12);
        chk("add_rsp_zero", bus.rsp_zero, 0);
        step();
        @(negedge clk);
        chk("idle_alu_op", bus.alu_op, ALU_NOP);
        step();

        // Backpressure: result held stable, no grants, then accept + grant together
        drv(2'b01, ALU_XOR, 32'hF0, 32'h0F, ALU_ADD, 0, 0);
        step();
        bus.rsp_ready = 1'b0;
        drv(2'b01, ALU_ADD, 1, 1, ALU_ADD, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_res", bus.rsp_res, 32'hFF);
            chk("bp_req_ready", bus.req_ready, 2'b00);
            step();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", bus.req_ready, 2'b01);
        chk("bp_release_res", bus.rsp_res, 32'hFF);
        step();
        drv(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
        step();
        step();

        // Reset pulse while in HOLD
        drv(2'b01, ALU_AND, 32'hFF, 32'h0F, ALU_ADD, 0, 0);
        step();
        bus.rsp_ready = 1'b0;
        drv(2'b11, ALU_ADD, 2, 3, ALU_SUB, 9, 4);
        step();
        @(negedge clk);
        chk("hold_before_reset", bus.rsp_res, 32'h0F);
        step();
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_pulse_rsp_valid", bus.rsp_valid, 0);
        chk("rst_pulse_req_ready", bus.req_ready, 0);
        #1 rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_first", bus.req_ready, 2'b01);
        step();
        @(negedge clk);
        chk("post_reset_second", bus.req_ready, 2'b10);
        step();
        drv(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
        step();
        step();

        // Divide
`ifdef ALU_ARB_DIVZERO_EN
        drv(2'b01, ALU_DIV, 10, 0, ALU_ADD, 0, 0);
        @(negedge clk);
        chk("dz_alu_op", bus.alu_op, ALU_NOP);
        chk("dz_ready", bus.req_ready, 2'b01);
        step();
        drv(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
        @(negedge clk);
        chk("dz_rsp_res", bus.rsp_res, 32'hFFFF_FFFF);
        chk("dz_rsp_zero", bus.rsp_zero, 0);
        step();
`endif
        drv(2'b10, ALU_ADD, 0, 0, ALU_DIV, 10, 2);
        @(negedge clk);
        chk("div_alu_op", bus.alu_op, ALU_DIV);
        chk("div_ready", bus.req_ready, 2'b10);
        step();
        drv(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0);
        @(negedge clk);
        chk("div_rsp_res", bus.rsp_res, 5);
        chk("div_rsp_id", bus.rsp_id, 1);
        step();

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
